alu_reservation_station: RTL

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

---
 rtl/alu_reservation_station.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
// Age-ordered reservation station feeding a single ALU execute stage.
// Instructions are dispatched with operands that are either already valid or
// tagged with the producer's destination. Operands are woken by two result
// broadcast buses (CDB0 takes priority over CDB1). The oldest entry with both
// operands valid is presented combinationally on the Issue* outputs and
// removed on the next rising edge. Younger entries then slide down one slot.
//
// Ports
//   CLK, Reset (async, active-low), Flush (sync clear of all entries)
//   DispValid/DispReady + Disp* fields : dispatch handshake and instruction
//   CDB0*/CDB1*                        : result broadcast (tag, data, valid)
//   IssueValid + Issue* fields         : selected instruction, zero when idle
//   Count                              : number of occupied entries
module alu_reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        DispValid,
  output logic        DispReady,
  input  logic [3:0]  DispALUControl,
  input  logic [31:0] DispDataA,
  input  logic [31:0] DispDataB,
  input  logic [31:0] DispTagA,
  input  logic [31:0] DispTagB,
  input  logic        DispRdyA,
  input  logic        DispRdyB,
  input  logic [31:0] DispDest,
  input  logic        DispRegWrite,
  input  logic [31:0] CDB0Dest,
  input  logic [31:0] CDB1Dest,
  input  logic [31:0] CDB0Data,
  input  logic [31:0] CDB1Data,
  input  logic        CDB0Valid,
  input  logic        CDB1Valid,
  output logic        IssueValid,
  output logic [3:0]  IssueALUControl,
  output logic [31:0] IssueSrcA,
  output logic [31:0] IssueSrcB,
  output logic [31:0] IssueDest,
  output logic        IssueRegWrite,
  output logic [3:0]  Count
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] data_a;
    logic [31:0] tag_a;
    logic        rdy_a;
    logic [31:0] data_b;
    logic [31:0] tag_b;
    logic        rdy_b;
    logic [31:0] dest;
    logic        reg_write;
  } entry_t;

  entry_t     ent_q [DEPTH];
  entry_t     ent_d [DEPTH];
  logic [3:0] count_q;
  logic [3:0] count_d;

  logic       sel_valid_s;
  logic [3:0] sel_idx_s;
  entry_t     sel_ent_s;
  logic       disp_acc_s;
  logic [3:0] wr_idx_s;
  entry_t     disp_ent_s;
  entry_t     woken_s   [DEPTH+1];
  entry_t     shifted_s [DEPTH];

  // Operand capture: returns {rdy, data}; an already-ready operand is kept,
  // otherwise CDB0 is checked before CDB1.
  function automatic logic [32:0] wake_op(
    input logic        rdy,
    input logic [31:0] data,
    input logic [31:0] tag,
    input logic        c0_v,
    input logic [31:0] c0_tag,
    input logic [31:0] c0_data,
    input logic        c1_v,
    input logic [31:0] c1_tag,
    input logic [31:0] c1_data
  );
    logic [32:0] r;
    if (rdy) begin
      r = {1'b1, data};
    end else if (c0_v && (tag == c0_tag)) begin
      r = {1'b1, c0_data};
    end else if (c1_v && (tag == c1_tag)) begin
      r = {1'b1, c1_data};
    end else begin
      r = {1'b0, data};
    end
    return r;
  endfunction

  // Occupancy comes from the registered count only, so an issue in the same
  // cycle never opens a slot early.
  assign DispReady = (count_q < 4'(DEPTH));
  assign Count     = count_q;

  // Oldest-first select among entries whose registered readiness is complete.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = 4'd0;
    sel_ent_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_valid_s && ent_q[i].valid && ent_q[i].rdy_a && ent_q[i].rdy_b) begin
        sel_valid_s = 1'b1;
        sel_idx_s   = 4'(i);
        sel_ent_s   = ent_q[i];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // sel_ent_s is all-zero when nothing is selected, which zeroes the fields.
  assign IssueValid      = sel_valid_s;
  assign IssueALUControl = sel_ent_s.alu_ctrl;
  assign IssueSrcA       = sel_ent_s.data_a;
  assign IssueSrcB       = sel_ent_s.data_b;
  assign IssueDest       = sel_ent_s.dest;
  assign IssueRegWrite   = sel_ent_s.reg_write;

  // Next entry state: wakeup, then compaction over the issued slot, then
  // append the dispatched instruction at the first free slot.
  always_comb begin
    disp_acc_s = DispValid && DispReady && !Flush;
    wr_idx_s   = count_q - {3'b000, sel_valid_s};

    disp_ent_s           = '0;
    disp_ent_s.valid     = 1'b1;
    disp_ent_s.alu_ctrl  = DispALUControl;
    disp_ent_s.tag_a     = DispTagA;
    disp_ent_s.tag_b     = DispTagB;
    disp_ent_s.dest      = DispDest;
    disp_ent_s.reg_write = DispRegWrite;
    {disp_ent_s.rdy_a, disp_ent_s.data_a} = wake_op(DispRdyA, DispDataA, DispTagA,
        CDB0Valid, CDB0Dest, CDB0Data, CDB1Valid, CDB1Dest, CDB1Data);
    {disp_ent_s.rdy_b, disp_ent_s.data_b} = wake_op(DispRdyB, DispDataB, DispTagB,
        CDB0Valid, CDB0Dest, CDB0Data, CDB1Valid, CDB1Dest, CDB1Data);

    // The extra top slot is an empty entry shifted in when compacting.
    woken_s[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woken_s[i] = ent_q[i];
      {woken_s[i].rdy_a, woken_s[i].data_a} = wake_op(ent_q[i].rdy_a, ent_q[i].data_a,
          ent_q[i].tag_a, CDB0Valid, CDB0Dest, CDB0Data, CDB1Valid, CDB1Dest, CDB1Data);
      {woken_s[i].rdy_b, woken_s[i].data_b} = wake_op(ent_q[i].rdy_b, ent_q[i].data_b,
          ent_q[i].tag_b, CDB0Valid, CDB0Dest, CDB0Data, CDB1Valid, CDB1Dest, CDB1Data);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (sel_valid_s && (4'(i) >= sel_idx_s)) begin
        shifted_s[i] = woken_s[i+1];
      end else begin
        shifted_s[i] = woken_s[i];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (Flush) begin
        ent_d[i] = '0;
      end else if (disp_acc_s && (4'(i) == wr_idx_s)) begin
        ent_d[i] = disp_ent_s;
      end else begin
        ent_d[i] = shifted_s[i];
      end
    end

    if (Flush) begin
      count_d = 4'd0;
    end else begin
      count_d = count_q + {3'b000, disp_acc_s} - {3'b000, sel_valid_s};
    end
  end

  // Entry and count registers with asynchronous clear.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= 4'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
